// File: rtl/im2col_tensor_addr_gen_pkg.sv
// Shared types for the im2col address generator: per-level last flags and the advance step they select.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package im2col_tensor_addr_gen_pkg;

    // One flag per nesting level; a flag is high when that counter sits at its maximum.
    typedef struct packed {
        logic c;
        logic kx;
        logic ky;
        logic ox;
        logic oy;
    } last_t;

    // Which level advances on a handshake. STEP_END means the whole walk is finished.
    typedef enum logic [2:0] {
        STEP_C   = 3'd0,
        STEP_KX  = 3'd1,
        STEP_KY  = 3'd2,
        STEP_OX  = 3'd3,
        STEP_OY  = 3'd4,
        STEP_END = 3'd5
    } step_t;

    // The innermost counter that is not at its maximum is the one that increments.
    function automatic step_t step_of(input last_t l);
        step_t s;
        if (!l.c)       s = STEP_C;
        else if (!l.kx) s = STEP_KX;
        else if (!l.ky) s = STEP_KY;
        else if (!l.ox) s = STEP_OX;
        else if (!l.oy) s = STEP_OY;
        else            s = STEP_END;
        return s;
    endfunction

endpackage

// File: rtl/im2col_win_cnt.sv
// Five-level nested im2col counter (c, kx, ky, ox, oy) with per-level last flags.
// Latency: counters update on the clock edge of each advance; flags are combinational.
// Backpressure: counters freeze whenever advance is low.
module im2col_win_cnt
    import im2col_tensor_addr_gen_pkg::*;
#(
    parameter int TENSOR_W = 8,
    parameter int KERNEL_W = 4,
    parameter int CHAN_W   = 8
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clear,
    input  logic                advance,
    input  logic [KERNEL_W-1:0] k,
    input  logic [CHAN_W-1:0]   ch,
    input  logic [TENSOR_W-1:0] o,
    output logic [CHAN_W-1:0]   c_cnt,
    output last_t               last
);

    logic [KERNEL_W-1:0] kx_cnt;
    logic [KERNEL_W-1:0] ky_cnt;
    logic [TENSOR_W-1:0] ox_cnt;
    logic [TENSOR_W-1:0] oy_cnt;
    step_t               step;

    // Limits are only meaningful when k, ch and o are all non-zero; the top never advances otherwise.
    assign last.c  = (c_cnt  == ch - 1'b1);
    assign last.kx = (kx_cnt == k  - 1'b1);
    assign last.ky = (ky_cnt == k  - 1'b1);
    assign last.ox = (ox_cnt == o  - 1'b1);
    assign last.oy = (oy_cnt == o  - 1'b1);
    assign step    = step_of(last);

    // Increment the selected level and zero every level inside it; the final step wraps everything.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            c_cnt  <= '0;
            kx_cnt <= '0;
            ky_cnt <= '0;
            ox_cnt <= '0;
            oy_cnt <= '0;
        end else if (clear) begin
            c_cnt  <= '0;
            kx_cnt <= '0;
            ky_cnt <= '0;
            ox_cnt <= '0;
            oy_cnt <= '0;
        end else if (advance) begin
            case (step)
                STEP_C: begin
                    c_cnt <= c_cnt + 1'b1;
                end
                STEP_KX: begin
                    c_cnt  <= '0;
                    kx_cnt <= kx_cnt + 1'b1;
                end
                STEP_KY: begin
                    c_cnt  <= '0;
                    kx_cnt <= '0;
                    ky_cnt <= ky_cnt + 1'b1;
                end
                STEP_OX: begin
                    c_cnt  <= '0;
                    kx_cnt <= '0;
                    ky_cnt <= '0;
                    ox_cnt <= ox_cnt + 1'b1;
                end
                STEP_OY: begin
                    c_cnt  <= '0;
                    kx_cnt <= '0;
                    ky_cnt <= '0;
                    ox_cnt <= '0;
                    oy_cnt <= oy_cnt + 1'b1;
                end
                default: begin
                    c_cnt  <= '0;
                    kx_cnt <= '0;
                    ky_cnt <= '0;
                    ox_cnt <= '0;
                    oy_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/im2col_tensor_addr_gen.sv
// Streams channel-last tensor read addresses in im2col order; optional o_row_last via IM2COL_ROW_LAST_EN.
// Latency: first o_valid two cycles after start (IDLE->SETUP->RUN); done one cycle after the last beat.
// Backpressure: valid/ready; without i_ready the address, valid and all counters hold.
`ifndef TENSOR_SIZE
`define TENSOR_SIZE 8
`endif
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 4
`endif
`ifndef CHANNELS_SIZE
`define CHANNELS_SIZE 8
`endif
`ifndef STRIDE_SIZE
`define STRIDE_SIZE 4
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 20
`endif

module im2col_tensor_addr_gen
    import im2col_tensor_addr_gen_pkg::*;
#(
    parameter int TENSOR_W = `TENSOR_SIZE,
    parameter int KERNEL_W = `KERNEL_SIZE,
    parameter int CHAN_W   = `CHANNELS_SIZE,
    parameter int STRIDE_W = `STRIDE_SIZE,
    parameter int ADDR_W   = `ADDR_SIZE
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic [TENSOR_W-1:0] tensor_size,
    input  logic [KERNEL_W-1:0] kernel_size,
    input  logic [CHAN_W-1:0]   channels,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [TENSOR_W-1:0] out_size,
    output logic [ADDR_W-1:0]   o_addr,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                busy,
    output logic                done
`ifdef IM2COL_ROW_LAST_EN
    ,
    output logic                o_row_last
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SETUP = ST_SETUP,
        RUN   = ST_RUN,
        DONE  = ST_DONE
    } state_t;

    state_t state, state_nxt;

    logic [TENSOR_W-1:0] t_q;
    logic [KERNEL_W-1:0] k_q;
    logic [CHAN_W-1:0]   c_q;
    logic [STRIDE_W-1:0] s_q;
    logic [TENSOR_W-1:0] o_q;

    logic [ADDR_W-1:0] tc_q, sc_q, stc_q;
    logic [ADDR_W-1:0] tc_calc, sc_calc, stc_calc;
    logic [ADDR_W-1:0] win_base, row_base, ky_base, kx_base;
    logic [ADDR_W-1:0] ky_nxt, win_nxt, row_nxt;
    logic [ADDR_W-1:0] c_ext;

    logic [CHAN_W-1:0] c_cnt;
    last_t             last;
    step_t             step;
    logic              handshake;
    logic              empty_walk;

    assign handshake  = o_valid && i_ready;
    assign empty_walk = (k_q == '0) || (c_q == '0) || (o_q == '0);
    assign step       = step_of(last);

    // Strides are formed once in SETUP so RUN only ever adds.
    assign tc_calc  = ADDR_W'(t_q) * ADDR_W'(c_q);
    assign sc_calc  = ADDR_W'(s_q) * ADDR_W'(c_q);
    assign stc_calc = ADDR_W'(s_q) * tc_calc;

    assign c_ext   = ADDR_W'(c_q);
    assign ky_nxt  = ky_base + tc_q;
    assign win_nxt = win_base + sc_q;
    assign row_nxt = row_base + stc_q;
    assign o_addr  = kx_base + ADDR_W'(c_cnt);

`ifdef IM2COL_ROW_LAST_EN
    assign o_row_last = o_valid && last.c && last.kx && last.ky;
`endif

    im2col_win_cnt #(
        .TENSOR_W (TENSOR_W),
        .KERNEL_W (KERNEL_W),
        .CHAN_W   (CHAN_W)
    ) u_win_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (state == SETUP),
        .advance (handshake),
        .k       (k_q),
        .ch      (c_q),
        .o       (o_q),
        .c_cnt   (c_cnt),
        .last    (last)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and status outputs; start outside IDLE falls through untouched.
    always_comb begin
        state_nxt = state;
        o_valid   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = SETUP;
            end
            SETUP: begin
                state_nxt = empty_walk ? DONE : RUN;
            end
            RUN: begin
                o_valid = 1'b1;
                if (handshake && step == STEP_END) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the job parameters only on an accepted start; later input changes are ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            t_q <= '0;
            k_q <= '0;
            c_q <= '0;
            s_q <= '0;
            o_q <= '0;
        end else if (state == IDLE && start) begin
            t_q <= tensor_size;
            k_q <= kernel_size;
            c_q <= channels;
            s_q <= stride;
            o_q <= out_size;
        end
    end

    // Base-address accumulators: each level restarts every inner base from its own new value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tc_q     <= '0;
            sc_q     <= '0;
            stc_q    <= '0;
            win_base <= '0;
            row_base <= '0;
            ky_base  <= '0;
            kx_base  <= '0;
        end else if (state == SETUP) begin
            tc_q     <= tc_calc;
            sc_q     <= sc_calc;
            stc_q    <= stc_calc;
            win_base <= '0;
            row_base <= '0;
            ky_base  <= '0;
            kx_base  <= '0;
        end else if (handshake) begin
            case (step)
                STEP_C: begin
                end
                STEP_KX: begin
                    kx_base <= kx_base + c_ext;
                end
                STEP_KY: begin
                    ky_base <= ky_nxt;
                    kx_base <= ky_nxt;
                end
                STEP_OX: begin
                    win_base <= win_nxt;
                    ky_base  <= win_nxt;
                    kx_base  <= win_nxt;
                end
                STEP_OY: begin
                    row_base <= row_nxt;
                    win_base <= row_nxt;
                    ky_base  <= row_nxt;
                    kx_base  <= row_nxt;
                end
                default: begin
                    win_base <= '0;
                    row_base <= '0;
                    ky_base  <= '0;
                    kx_base  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im2col_tensor_addr_gen.sv
// Scoreboard bench for im2col_tensor_addr_gen: directed jobs push expected beats, a monitor pops and compares.
// Latency: checks first-valid and done timing against the start cycle.
// Backpressure: drives i_ready low mid-run and checks the held beat.
module tb_im2col_tensor_addr_gen;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  tensor_size = '0;
    logic [3:0]  kernel_size = '0;
    logic [7:0]  channels = '0;
    logic [3:0]  stride = '0;
    logic [7:0]  out_size = '0;
    logic [19:0] o_addr;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic        busy;
    logic        done;
`ifdef IM2COL_ROW_LAST_EN
    logic        o_row_last;
`endif

    im2col_tensor_addr_gen dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .tensor_size (tensor_size),
        .kernel_size (kernel_size),
        .channels    (channels),
        .stride      (stride),
        .out_size    (out_size),
        .o_addr      (o_addr),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .busy        (busy),
        .done        (done)
`ifdef IM2COL_ROW_LAST_EN
        ,
        .o_row_last  (o_row_last)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [19:0] addr;
        logic        rl;
    } exp_t;

    exp_t sbq[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor-owned observations
    int beats = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_hs_cyc = -1;
    int valid_rise_cyc = -1;
    int busy_cnt = 0;

    int tab1 [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};
    int tab2 [32] = '{0, 1, 2, 3, 6, 7, 8, 9,     2, 3, 4, 5, 8, 9, 10, 11,
                      6, 7, 8, 9, 12, 13, 14, 15, 8, 9, 10, 11, 14, 15, 16, 17};

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_case1(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = 20'(tab1[i]);
            e.rl   = ((i % 4) == 3);
            sbq.push_back(e);
        end
    endtask

    task automatic push_case2();
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            e.addr = 20'(tab2[i]);
            e.rl   = ((i % 8) == 7);
            sbq.push_back(e);
        end
    endtask

    task automatic do_start(input int t, input int k, input int c, input int s, input int o,
                            output int sc);
        tick();
        tensor_size = 8'(t);
        kernel_size = 4'(k);
        channels    = 8'(c);
        stride      = 4'(s);
        out_size    = 8'(o);
        start       = 1'b1;
        sc          = cyc;
        tick();
        start       = 1'b0;
        tensor_size = 8'd200;
        kernel_size = 4'd7;
        channels    = 8'd9;
        stride      = 4'd3;
        out_size    = 8'd50;
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt != d0) begin
                seen = 1'b1;
                break;
            end
        end
        chk(name, done_cnt - d0, 1);
    endtask

    // Monitor: pops the scoreboard on every accepted beat and checks hold behaviour under backpressure.
    initial begin : monitor
        logic        pv;
        logic        prdy;
        logic [19:0] pa;
        exp_t        e;
        pv = 1'b0;
        prdy = 1'b1;
        pa = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pv = 1'b0;
            end else begin
                if (pv && !prdy) begin
                    chk("hold_valid", o_valid, 1);
                    chk("hold_addr", o_addr, pa);
                end
                if (o_valid && !pv) valid_rise_cyc = cyc;
                if (o_valid && i_ready) begin
                    beats++;
                    last_hs_cyc = cyc;
                    if (sbq.size() == 0) begin
                        chk("beat_expected", sbq.size(), 1);
                    end else begin
                        e = sbq.pop_front();
                        chk("addr", o_addr, e.addr);
`ifdef IM2COL_ROW_LAST_EN
                        chk("row_last", o_row_last, e.rl);
`endif
                    end
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (busy) busy_cnt++;
                pv   = o_valid;
                prdy = i_ready;
                pa   = o_addr;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Stimulus
    initial begin : stim
        int s;
        int b0;
        int bz0;
        int d0;
        repeat (3) tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rstn = 1'b1;
        tick();

        // Job 1: T=4 K=2 C=1 S=2 O=2, free-flowing
        push_case1(16);
        b0 = beats;
        bz0 = busy_cnt;
        do_start(4, 2, 1, 2, 2, s);
        wait_done("c1_done", 60);
        tick();
        chk("c1_first_valid", valid_rise_cyc - s, 2);
        chk("c1_done_lat", done_cyc - last_hs_cyc, 1);
        chk("c1_beats", beats - b0, 16);
        chk("c1_busy_cycles", busy_cnt - bz0, 18);
        chk("c1_sb_empty", sbq.size(), 0);

        // Job 2: T=3 K=2 C=2 S=1 O=2
        push_case2();
        b0 = beats;
        do_start(3, 2, 2, 1, 2, s);
        wait_done("c2_done", 80);
        tick();
        chk("c2_beats", beats - b0, 32);
        chk("c2_sb_empty", sbq.size(), 0);

        // Job 3: job 1 with i_ready low for three cycles while address 1 is presented
        push_case1(16);
        b0 = beats;
        do_start(4, 2, 1, 2, 2, s);
        tick();
        tick();
        i_ready = 1'b0;
        repeat (3) tick();
        i_ready = 1'b1;
        wait_done("bp_done", 60);
        tick();
        chk("bp_beats", beats - b0, 16);
        chk("bp_done_cyc", done_cyc - s, 21);
        chk("bp_sb_empty", sbq.size(), 0);

        // Job 4: empty walks (O=0, then C=0)
        b0 = beats;
        bz0 = busy_cnt;
        do_start(4, 2, 1, 2, 0, s);
        wait_done("o0_done", 10);
        chk("o0_done_cyc", done_cyc - s, 2);
        chk("o0_busy_cycles", busy_cnt - bz0, 2);
        bz0 = busy_cnt;
        do_start(4, 2, 0, 2, 2, s);
        wait_done("c0_done", 10);
        chk("c0_done_cyc", done_cyc - s, 2);
        chk("c0_busy_cycles", busy_cnt - bz0, 2);
        chk("empty_beats", beats - b0, 0);

        // Job 5: start re-pulsed mid-run and in the DONE cycle
        push_case1(16);
        b0 = beats;
        d0 = done_cnt;
        do_start(4, 2, 1, 2, 2, s);
        repeat (5) tick();
        tensor_size = 8'd3;
        kernel_size = 4'd3;
        channels    = 8'd3;
        stride      = 4'd1;
        out_size    = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && cyc < s + 18; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("rs_done_cyc", done_cyc - s, 18);
        chk("rs_beats", beats - b0, 16);
        chk("rs_done_count", done_cnt - d0, 1);
        chk("rs_idle_busy", busy, 0);
        chk("rs_sb_empty", sbq.size(), 0);

        // Job 6: reset after five beats, then a clean rerun
        push_case1(5);
        b0 = beats;
        do_start(4, 2, 1, 2, 2, s);
        repeat (6) tick();
        rstn = 1'b0;
        d0 = done_cnt;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_addr", o_addr, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        tick();
        tick();
        rstn = 1'b1;
        repeat (4) tick();
        chk("arst_beats", beats - b0, 5);
        chk("arst_no_done", done_cnt - d0, 0);
        chk("arst_sb_empty", sbq.size(), 0);

        push_case1(16);
        b0 = beats;
        do_start(4, 2, 1, 2, 2, s);
        wait_done("rerun_done", 60);
        tick();
        chk("rerun_first_valid", valid_rise_cyc - s, 2);
        chk("rerun_beats", beats - b0, 16);
        chk("rerun_sb_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
